// File: rtl/mcu_spi_hub.sv
// rtl/mcu_spi_hub.sv - SPI slave hub: byte 0 selects a target, payload bytes strobe it, replies go out on MISO.
// Define MCU_SPI_HUB_ID_EN to reserve target 8'hFF as an identity responder (CORE_ID, NUM_TARGETS, zeros).
module mcu_spi_hub #(
  parameter int         NUM_TARGETS = 4,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] CORE_ID     = 8'h5A
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     spi_io_ss,
  input  logic                     spi_io_clk,
  input  logic                     spi_io_din,
  output logic                     spi_io_dout,
  output logic [NUM_TARGETS-1:0]   mcu_strobe,
  output logic                     mcu_start,
  input  logic [8*NUM_TARGETS-1:0] mcu_din,
  output logic [7:0]               mcu_dout,
  output logic [7:0]               mcu_target,
  output logic                     mcu_err
);

`ifdef MCU_SPI_HUB_ID_EN
  localparam bit ID_EN = 1'b1;
`else
  localparam bit ID_EN = 1'b0;
`endif

  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] din_sync_q, din_sync_d;
  logic                   sclk_dly_q, sclk_dly_d;
  logic                   rise_q, rise_d;
  logic                   armed_q, armed_d;
  logic                   byte_done_q, byte_done_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [3:0]             byte_cnt_q, byte_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   dout_q, dout_d;
  logic [NUM_TARGETS-1:0] strobe_q, strobe_d;
  logic                   start_q, start_d;
  logic                   err_q, err_d;
  logic [7:0]             mcu_dout_q, mcu_dout_d;
  logic [7:0]             mcu_target_q, mcu_target_d;

  logic       ss_s, sclk_s, din_s, sclk_fall, sclk_rise;
  logic       mapped, id_sel;
  logic [7:0] reply;

  always_comb begin
    ss_s      = ss_sync_q[SYNC_STAGES-1];
    sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    din_s     = din_sync_q[SYNC_STAGES-1];
    sclk_fall = sclk_dly_q & ~sclk_s;
    sclk_rise = ~sclk_dly_q & sclk_s;
    mapped    = 32'(mcu_target_q) < NUM_TARGETS;
    id_sel    = ID_EN && (mcu_target_q == 8'hFF);
    // Reply byte is sampled live from the addressed target; byte 0 always answers zero.
    reply     = 8'h00;
    if (byte_cnt_q != 4'd0) begin
      if (mapped) begin
        for (int i = 0; i < NUM_TARGETS; i++) begin
          if (mcu_target_q == 8'(i)) reply = mcu_din[8*i +: 8];
        end
      end else if (id_sel) begin
        if (byte_cnt_q == 4'd1)      reply = CORE_ID;
        else if (byte_cnt_q == 4'd2) reply = 8'(NUM_TARGETS);
      end
    end
  end

  always_comb begin
    ss_sync_d    = {ss_sync_q[SYNC_STAGES-2:0], spi_io_ss};
    sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], spi_io_clk};
    din_sync_d   = {din_sync_q[SYNC_STAGES-2:0], spi_io_din};
    sclk_dly_d   = sclk_s;
    rise_d       = sclk_rise;
    armed_d      = armed_q | ss_s;
    byte_done_d  = 1'b0;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    shift_d      = shift_q;
    dout_d       = dout_q;
    strobe_d     = '0;
    start_d      = 1'b0;
    err_d        = 1'b0;
    mcu_dout_d   = mcu_dout_q;
    mcu_target_d = mcu_target_q;

    // A completed byte is dispatched one cycle after its last SCLK fall.
    if (byte_done_q) begin
      if (byte_cnt_q == 4'd0) begin
        mcu_target_d = shift_q;
      end else begin
        mcu_dout_d = shift_q;
        if (mapped) begin
          for (int i = 0; i < NUM_TARGETS; i++) begin
            strobe_d[i] = (mcu_target_q == 8'(i));
          end
          start_d = (byte_cnt_q == 4'd1);
        end else if (!id_sel) begin
          err_d = 1'b1;
        end
      end
      if (byte_cnt_q != 4'd15) byte_cnt_d = byte_cnt_q + 4'd1;
    end

    // Deselect wins over any coincident SCLK edge; nothing is sampled until ss has been seen high.
    if (ss_s) begin
      bit_cnt_d  = 3'd0;
      byte_cnt_d = 4'd0;
      shift_d    = 8'h00;
      dout_d     = 1'b0;
    end else if (armed_q) begin
      if (sclk_fall) begin
        shift_d     = {shift_q[6:0], din_s};
        bit_cnt_d   = bit_cnt_q + 3'd1;
        byte_done_d = (bit_cnt_q == 3'd7);
      end
      if (rise_q) dout_d = reply[3'd7 - bit_cnt_q];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ss_sync_q    <= '0;
      sclk_sync_q  <= '0;
      din_sync_q   <= '0;
      sclk_dly_q   <= 1'b0;
      rise_q       <= 1'b0;
      armed_q      <= 1'b0;
      byte_done_q  <= 1'b0;
      bit_cnt_q    <= 3'd0;
      byte_cnt_q   <= 4'd0;
      shift_q      <= 8'h00;
      dout_q       <= 1'b0;
      strobe_q     <= '0;
      start_q      <= 1'b0;
      err_q        <= 1'b0;
      mcu_dout_q   <= 8'h00;
      mcu_target_q <= 8'h00;
    end else begin
      ss_sync_q    <= ss_sync_d;
      sclk_sync_q  <= sclk_sync_d;
      din_sync_q   <= din_sync_d;
      sclk_dly_q   <= sclk_dly_d;
      rise_q       <= rise_d;
      armed_q      <= armed_d;
      byte_done_q  <= byte_done_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      shift_q      <= shift_d;
      dout_q       <= dout_d;
      strobe_q     <= strobe_d;
      start_q      <= start_d;
      err_q        <= err_d;
      mcu_dout_q   <= mcu_dout_d;
      mcu_target_q <= mcu_target_d;
    end
  end

  assign spi_io_dout = dout_q;
  assign mcu_strobe  = strobe_q;
  assign mcu_start   = start_q;
  assign mcu_err     = err_q;
  assign mcu_dout    = mcu_dout_q;
  assign mcu_target  = mcu_target_q;

endmodule

// File: tb/tb_mcu_spi_hub.sv
// tb/tb_mcu_spi_hub.sv - scoreboard bench for mcu_spi_hub with a transfer-level reference model.
module tb_mcu_spi_hub;
  localparam int NT = 4;
  localparam logic [7:0] CID = 8'h5A;
`ifdef MCU_SPI_HUB_ID_EN
  localparam bit ID_EN = 1'b1;
`else
  localparam bit ID_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          spi_io_ss = 1'b1;
  logic          spi_io_clk = 1'b0;
  logic          spi_io_din = 1'b0;
  logic          spi_io_dout;
  logic [NT-1:0] mcu_strobe;
  logic          mcu_start;
  logic [8*NT-1:0] mcu_din = '0;
  logic [7:0]    mcu_dout;
  logic [7:0]    mcu_target;
  logic          mcu_err;

  mcu_spi_hub #(.NUM_TARGETS(NT), .SYNC_STAGES(2), .CORE_ID(CID)) dut (
    .clk(clk), .reset(reset), .spi_io_ss(spi_io_ss), .spi_io_clk(spi_io_clk),
    .spi_io_din(spi_io_din), .spi_io_dout(spi_io_dout), .mcu_strobe(mcu_strobe),
    .mcu_start(mcu_start), .mcu_din(mcu_din), .mcu_dout(mcu_dout),
    .mcu_target(mcu_target), .mcu_err(mcu_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NT-1:0] strobe;
    logic          start;
    logic          err;
    logic [7:0]    dout;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] pay_q[$];
  logic [7:0] din_v[NT];
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_din();
    for (int i = 0; i < NT; i++) mcu_din[8*i +: 8] = din_v[i];
  endtask

  // Model: what a payload byte at position k (1-based) of a transfer to tgt should produce.
  function automatic logic [7:0] model_reply(input logic [7:0] tgt, input int k);
    if (tgt < NT) return din_v[tgt];
    if (ID_EN && tgt == 8'hFF) return (k == 1) ? CID : (k == 2) ? 8'(NT) : 8'h00;
    return 8'h00;
  endfunction

  task automatic push_expect(input logic [7:0] tgt, input int k, input logic [7:0] b);
    ev_t e;
    if (ID_EN && tgt == 8'hFF) return;
    e.strobe = (tgt < NT) ? NT'(1) << tgt : '0;
    e.start  = (tgt < NT) && (k == 1);
    e.err    = !(tgt < NT);
    e.dout   = b;
    exp_q.push_back(e);
  endtask

  // Mode 1: master changes MOSI on rising SCLK, slave samples on falling; MISO read just before the fall.
  task automatic spi_byte(input logic [7:0] b, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_io_clk = 1'b1;
      spi_io_din = b[i];
      #50;
      rx[i] = spi_io_dout;
      spi_io_clk = 1'b0;
      #50;
    end
  endtask

  task automatic xfer(input logic [7:0] tgt);
    logic [7:0] rx;
    spi_io_ss = 1'b0;
    #50;
    spi_byte(tgt, 8, rx);
    chk("miso_byte0", 32'(rx), 32'h0);
    for (int k = 1; k <= pay_q.size(); k++) begin
      push_expect(tgt, k, pay_q[k-1]);
      spi_byte(pay_q[k-1], 8, rx);
      chk($sformatf("miso_t%0h_b%0d", tgt, k), 32'(rx), 32'(model_reply(tgt, k)));
    end
    #50;
    spi_io_ss = 1'b1;
    #100;
  endtask

  always @(negedge clk) begin
    if (!reset && (mcu_strobe != '0 || mcu_start || mcu_err)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: strobe=%b start=%b err=%b dout=0x%0h expected none",
                 mcu_strobe, mcu_start, mcu_err, mcu_dout);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("ev_strobe", 32'(mcu_strobe), 32'(e.strobe));
        chk("ev_start", 32'(mcu_start), 32'(e.start));
        chk("ev_err", 32'(mcu_err), 32'(e.err));
        chk("ev_dout", 32'(mcu_dout), 32'(e.dout));
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_dout_pin"}, 32'(spi_io_dout), 32'h0);
    chk({tag, "_strobe"}, 32'(mcu_strobe), 32'h0);
    chk({tag, "_start"}, 32'(mcu_start), 32'h0);
    chk({tag, "_err"}, 32'(mcu_err), 32'h0);
    chk({tag, "_mcu_dout"}, 32'(mcu_dout), 32'h0);
    chk({tag, "_target"}, 32'(mcu_target), 32'h0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rx;
    logic [7:0] t;
    int r;
    for (int i = 0; i < NT; i++) din_v[i] = 8'h00;
    set_din();
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    repeat (5) @(negedge clk);
    #2;

    // Basic write
    pay_q = '{8'hA5, 8'h3C};
    xfer(8'h02);
    chk("basic_target", 32'(mcu_target), 32'h02);
    chk("basic_dout_held", 32'(mcu_dout), 32'h3C);

    // Readback
    din_v[1] = 8'h96;
    set_din();
    pay_q = '{8'h00};
    xfer(8'h01);

    // Abort after 5 bits of byte 1, then a clean transfer
    spi_io_ss = 1'b0;
    #50;
    spi_byte(8'h02, 8, rx);
    spi_byte(8'hFF, 5, rx);
    spi_io_ss = 1'b1;
    #100;
    pay_q = '{8'h11};
    xfer(8'h00);
    chk("abort_next_dout", 32'(mcu_dout), 32'h11);

    // Unmapped target
    pay_q = '{8'h55};
    xfer(8'h07);

    // Identity target (behaviour depends on the build)
    pay_q = '{8'h00, 8'h00, 8'h00};
    xfer(8'hFF);

    // Randomised transfers
    for (int n = 0; n < 14; n++) begin
      for (int i = 0; i < NT; i++) din_v[i] = 8'($urandom);
      set_din();
      r = $urandom_range(0, 9);
      if (r < 4)       t = 8'(r);
      else if (r < 8)  t = 8'(r + 4 * $urandom_range(0, 50));
      else if (r == 8) t = 8'hFF;
      else             t = 8'($urandom_range(4, 254));
      pay_q.delete();
      for (int k = 0; k < $urandom_range(1, 4); k++) pay_q.push_back(8'($urandom));
      xfer(t);
    end

    // Reset in the middle of a byte
    pay_q = '{8'h77};
    xfer(8'h03);
    spi_io_ss = 1'b0;
    #50;
    spi_byte(8'h01, 8, rx);
    spi_byte(8'hC3, 4, rx);
    #3 reset = 1'b1;
    #1;
    check_idle_outputs("midreset");
    spi_io_ss = 1'b1;
    spi_io_clk = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    #2;

    // Long transfer past the byte-counter saturation point
    din_v[3] = 8'hE1;
    set_din();
    pay_q.delete();
    for (int k = 0; k < 20; k++) pay_q.push_back(8'($urandom));
    xfer(8'h03);

    repeat (20) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mcu_spi_hub.md
# mcu_spi_hub

Single-clock SPI slave linking the board MCU to up to `NUM_TARGETS` core byte targets (sys, HID, OSD, SD card, …). All SPI pins are oversampled and edge-detected in the `clk` domain; there is no logic clocked by `spi_io_clk`. The first byte of each `spi_io_ss`-framed transfer selects a target. Later bytes are strobed to that target, and the target's reply byte is shifted back on MISO. It replaces the fixed four-target MCU interface.

## Interface
- `NUM_TARGETS`, 4: number of byte targets, 1..16; target IDs 0..NUM_TARGETS-1.
- `SYNC_STAGES`, 2: synchroniser depth for `spi_io_ss`, `spi_io_clk` and `spi_io_din`; range 2..3.
- `CORE_ID`, 8'h5A: identity byte returned by target 0xFF (see Configuration).
- `clk` in 1: core clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `spi_io_ss` in 1: chip select, active low; a transfer is framed while low.
- `spi_io_clk` in 1: SPI clock, mode 1.
- `spi_io_din` in 1: MOSI.
- `spi_io_dout` out 1: MISO; registered.
- `mcu_strobe` out NUM_TARGETS: one-hot 1-cycle pulse, one bit per target.
- `mcu_start` out 1: 1-cycle pulse coincident with the first payload strobe of a transfer.
- `mcu_din` in 8*NUM_TARGETS: reply byte of target i on bits [8i+7:8i].
- `mcu_dout` out 8: last payload byte received; held until the next payload byte.
- `mcu_target` out 8: target ID latched from byte 0 of the current or last transfer.
- `mcu_err` out 1: 1-cycle pulse when a payload byte is addressed to an unmapped ID.

## Operation
- **Reset values:** `spi_io_dout`=0, `mcu_strobe`=0, `mcu_start`=0, `mcu_dout`=8'h00, `mcu_target`=8'h00, `mcu_err`=0. Bit counter, byte counter and shift register are cleared.
- **Synchronisation and edges:** each SPI input passes through `SYNC_STAGES` flops. A falling or rising SCLK edge is detected by comparing the last synchroniser stage with one extra delayed copy.
- **Framing:** ss synchronised high clears the 3-bit bit counter, the 4-bit byte counter and the shift register. It also drives `spi_io_dout` to 0 on the next cycle and discards any partial byte, with no strobe.
- **Receive:** on each falling SCLK edge with ss low, shift `spi_io_din` in MSB-first and increment the bit counter.
- **Byte complete (bit counter wraps 7→0):**
  - Byte count 0: latch the byte into `mcu_target`; no strobe.
  - Byte count ≥1: load `mcu_dout`. If `mcu_target` < NUM_TARGETS, pulse `mcu_strobe[mcu_target]`; otherwise pulse `mcu_err`. Pulse `mcu_start` as well when the byte count is 1 and the target is mapped.
  - The byte counter saturates at 15; payload bytes keep strobing past 15 with no limit.
- **Transmit:** on each rising SCLK edge with ss low, drive `spi_io_dout` with bit `7-bitcnt` of the reply byte.
  - The reply is `mcu_din` slice `mcu_target` while the byte count is ≥1 and the target is mapped; otherwise 8'h00.
  - During byte 0 the reply is always 0.
  - The reply byte is read live, so a target must hold its reply stable for the whole byte.
- **Simultaneous ss rise and SCLK edge in the same cycle:** ss wins; the edge is ignored.

## Timing
- `spi_io_clk` high and low phases must each last ≥ SYNC_STAGES+1 `clk` periods; f_sclk ≤ f_clk/(2·(SYNC_STAGES+1)). At 32 MHz with SYNC_STAGES=2 this gives ≤5.3 MHz.
- Strobe latency: `mcu_strobe`, `mcu_start` and `mcu_err` assert exactly SYNC_STAGES+2 `clk` edges after the pin-level falling edge of bit 7, with up to one cycle of synchroniser jitter.
- `mcu_dout` is valid in the same cycle as the strobe.
- MISO update latency matches the strobe latency, relative to the rising SCLK edge. MOSI and SS setup must cover one SCLK phase.
- Back-to-back transfers need ss high for ≥ SYNC_STAGES+1 `clk` periods.
- Reset mid-transfer: everything returns to reset values immediately. The next transfer must begin with a fresh ss falling edge; bytes before it are ignored.

## Configuration
- `MCU_SPI_HUB_ID_EN`:
  - **Defined:** target ID 8'hFF is reserved. Its payload bytes return `CORE_ID` then `NUM_TARGETS`, then 8'h00 repeating. No strobe and no `mcu_err` is generated.
  - **Undefined:** 8'hFF is treated like any unmapped ID (reply 0, `mcu_err` pulses).

## Test plan
- **Basic write:** NUM_TARGETS=4; send 0x02,0xA5,0x3C → `mcu_strobe`=4'b0100 twice, with `mcu_dout` = 0xA5 then 0x3C. `mcu_start` pulses only with the 0xA5 strobe. `mcu_target`=0x02.
- **Readback:** `mcu_din` slice 1 = 0x96; send 0x01,0x00 → MISO bits during byte 1 are 1,0,0,1,0,1,1,0 and 0 throughout byte 0.
- **Abort:** ss rises after 5 bits of byte 1 → no strobe, counters cleared. The next transfer 0x00,0x11 produces `mcu_strobe[0]` with `mcu_dout`=0x11.
- **Unmapped target:** send 0x07,0x55 → `mcu_err` pulses once, `mcu_strobe`=0, MISO all 0.
- **ID feature:** with `MCU_SPI_HUB_ID_EN` defined, send 0xFF,0,0,0 → MISO returns 0x5A,0x04,0x00 and `mcu_err` stays 0. Without the macro, `mcu_err` pulses three times.
- **Reset:** assert `reset` mid-byte → all outputs 0 within the same cycle. Send 20 payload bytes → 20 strobes, with the byte counter saturated at 15.
